// File: rtl/rstack_ctrl.sv
// Return stack controller: stack pointer, occupancy, sticky error flags, async top/peek reads.
// Define RSTACK_GUARD_EN to enable full/empty guarding and overflow/underflow flags.
module rstack_ctrl #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DATA_WIDTH = 13,
    parameter bit          WRAP       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] top,
    input  logic [WIDTH-1:0]      peek_depth,
    output logic [DATA_WIDTH-1:0] peek_dout,
    output logic [WIDTH:0]        level,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int unsigned SIZE = 2 ** WIDTH;
    localparam logic [WIDTH:0] LEVEL_MAX = (WIDTH + 1)'(SIZE);
    localparam logic [WIDTH:0] LEVEL_ONE = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] SP_ONE = WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [SIZE];
    logic [WIDTH-1:0]      r_sp;
    logic [WIDTH:0]        r_level;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_we;
    logic [WIDTH-1:0]      w_waddr;
    logic [WIDTH-1:0]      w_sp_next;
    logic [WIDTH:0]        w_level_next;
    logic [WIDTH-1:0]      w_top_addr;
    logic [WIDTH-1:0]      w_peek_addr;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == LEVEL_MAX);
    assign w_top_addr  = r_sp - SP_ONE;
    assign w_peek_addr = r_sp - SP_ONE - peek_depth;

`ifdef RSTACK_GUARD_EN
    logic r_ovf;
    logic r_unf;
    logic w_ovf_next;
    logic w_unf_next;

    always_comb begin
        w_we         = 1'b0;
        w_waddr      = r_sp;
        w_sp_next    = r_sp;
        w_level_next = r_level;
        // Clear first so an error raised in the same cycle wins.
        w_ovf_next   = r_ovf & ~err_clr;
        w_unf_next   = r_unf & ~err_clr;
        case ({push, pop})
            2'b10: begin
                if (!w_full) begin
                    w_we         = 1'b1;
                    w_sp_next    = r_sp + SP_ONE;
                    w_level_next = r_level + LEVEL_ONE;
                end else begin
                    w_ovf_next = 1'b1;
                    if (WRAP) begin
                        w_we      = 1'b1;
                        w_sp_next = r_sp + SP_ONE;
                    end
                end
            end
            2'b01: begin
                if (!w_empty) begin
                    w_sp_next    = r_sp - SP_ONE;
                    w_level_next = r_level - LEVEL_ONE;
                end else begin
                    w_unf_next = 1'b1;
                end
            end
            2'b11: begin
                w_we = 1'b1;
                if (w_empty) begin
                    w_sp_next    = r_sp + SP_ONE;
                    w_level_next = LEVEL_ONE;
                    w_unf_next   = 1'b1;
                end else begin
                    w_waddr = w_top_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_next;
            r_unf <= w_unf_next;
        end
    end

    assign overflow  = r_ovf;
    assign underflow = r_unf;
`else
    logic w_unused;
    assign w_unused = err_clr ^ WRAP;

    always_comb begin
        w_we         = 1'b0;
        w_waddr      = r_sp;
        w_sp_next    = r_sp;
        w_level_next = r_level;
        case ({push, pop})
            2'b10: begin
                w_we      = 1'b1;
                w_sp_next = r_sp + SP_ONE;
                if (!w_full) w_level_next = r_level + LEVEL_ONE;
            end
            2'b01: begin
                w_sp_next = r_sp - SP_ONE;
                if (!w_empty) w_level_next = r_level - LEVEL_ONE;
            end
            2'b11: begin
                w_we    = 1'b1;
                w_waddr = w_top_addr;
            end
            default: ;
        endcase
    end

    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp    <= '0;
            r_level <= '0;
        end else begin
            r_sp    <= w_sp_next;
            r_level <= w_level_next;
        end
    end

    // Storage is not reset; gating on reset keeps a command pending at reset from landing.
    always_ff @(posedge clk) begin
        if (w_we && !reset) r_mem[w_waddr] <= din;
    end

    assign top       = w_empty ? '0 : r_mem[w_top_addr];
    assign peek_dout = ({1'b0, peek_depth} < r_level) ? r_mem[w_peek_addr] : '0;
    assign level     = r_level;
    assign empty     = w_empty;
    assign full      = w_full;

endmodule

// File: tb/tb_rstack_ctrl.sv
// Directed bench for rstack_ctrl (WIDTH=2); one instance with WRAP=1, one with WRAP=0.
module tb_rstack_ctrl;

    localparam int unsigned W  = 2;
    localparam int unsigned DW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] din = '0;
    logic [W-1:0]  peek_depth = '0;

    logic [DW-1:0] top_a, peek_a, top_b, peek_b;
    logic [W:0]    level_a, level_b;
    logic          empty_a, full_a, ovf_a, unf_a;
    logic          empty_b, full_b, ovf_b, unf_b;

    int checks = 0;
    int errors = 0;

`ifdef RSTACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    rstack_ctrl #(.WIDTH(W), .DATA_WIDTH(DW), .WRAP(1'b1)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .top(top_a),
        .peek_depth(peek_depth), .peek_dout(peek_a), .level(level_a), .empty(empty_a),
        .full(full_a), .overflow(ovf_a), .underflow(unf_a), .err_clr(err_clr)
    );

    rstack_ctrl #(.WIDTH(W), .DATA_WIDTH(DW), .WRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .top(top_b),
        .peek_depth(peek_depth), .peek_dout(peek_b), .level(level_b), .empty(empty_b),
        .full(full_b), .overflow(ovf_b), .underflow(unf_b), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic p, input logic q, input logic [DW-1:0] d, input logic c);
        @(negedge clk);
        push = p; pop = q; din = d; err_clr = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_level", 32'(level_a), 0);
        chk("rst_empty", 32'(empty_a), 1);
        chk("rst_full", 32'(full_a), 0);
        chk("rst_ovf", 32'(ovf_a), 0);
        chk("rst_unf", 32'(unf_a), 0);
        chk("rst_top", 32'(top_a), 0);

        // Basic push / peek / pop
        step(1, 0, 13'h001, 0);
        step(1, 0, 13'h002, 0);
        step(1, 0, 13'h003, 0);
        chk("push3_top", 32'(top_a), 32'h003);
        chk("push3_level", 32'(level_a), 3);
        peek_depth = 2'd2; #1;
        chk("peek2", 32'(peek_a), 32'h001);
        peek_depth = 2'd3; #1;
        chk("peek3_invalid", 32'(peek_a), 0);
        peek_depth = 2'd0;
        step(0, 1, '0, 0);
        step(0, 1, '0, 0);
        chk("pop2_top", 32'(top_a), 32'h001);
        chk("pop2_level", 32'(level_a), 1);
        step(0, 1, '0, 0);
        chk("pop3_empty", 32'(empty_a), 1);

        // Fill, then push while full
        for (int i = 0; i < 4; i++) step(1, 0, DW'(32'h10 + i), 0);
        chk("fill_full", 32'(full_a), 1);
        chk("fill_top", 32'(top_a), 32'h13);
        step(1, 0, 13'h014, 0);
        chk("ovf_full", 32'(full_a), 1);
        chk("ovf_level", 32'(level_a), 4);
        chk("ovf_flag", 32'(ovf_a), 32'(GUARD));
        chk("ovf_top", 32'(top_a), 32'h14);
        peek_depth = 2'd3; #1;
        chk("ovf_peek3", 32'(peek_a), 32'h11);
        chk("w0_top", 32'(top_b), GUARD ? 32'h13 : 32'h14);
        chk("w0_peek3", 32'(peek_b), GUARD ? 32'h10 : 32'h11);
        chk("w0_level", 32'(level_b), 4);
        peek_depth = 2'd0;
        // err_clr with a new overflow in the same cycle: set wins
        step(1, 0, 13'h015, 1);
        chk("clr_set_ovf", 32'(ovf_a), 32'(GUARD));
        chk("clr_set_top", 32'(top_a), 32'h15);
        step(0, 0, '0, 1);
        chk("clr_ovf", 32'(ovf_a), 0);

        // Pop on empty
        do_reset();
        step(0, 1, '0, 0);
        chk("unf_flag", 32'(unf_a), 32'(GUARD));
        chk("unf_level", 32'(level_a), 0);
        chk("unf_top", 32'(top_a), 0);
        step(0, 0, '0, 1);
        chk("clr_unf", 32'(unf_a), 0);
        step(1, 0, 13'h007, 0);
        chk("pe_level", 32'(level_a), 1);
        chk("pe_top", 32'(top_a), 32'h007);
        chk("pe_unf", 32'(unf_a), 0);
        chk("pe_slot", 32'(dut.r_mem[GUARD ? 0 : 3]), 32'h007);

        // Replace
        step(1, 0, 13'h0AA, 0);
        chk("rep_pre_level", 32'(level_a), 2);
        step(1, 1, 13'h155, 0);
        chk("rep_top", 32'(top_a), 32'h155);
        chk("rep_level", 32'(level_a), 2);
        peek_depth = 2'd1; #1;
        chk("rep_next", 32'(peek_a), 32'h007);
        peek_depth = 2'd0;

        // Replace on empty
        do_reset();
        step(1, 1, 13'h01F, 0);
        chk("repe_level", 32'(level_a), GUARD ? 1 : 0);
        chk("repe_top", 32'(top_a), GUARD ? 32'h01F : 0);
        chk("repe_unf", 32'(unf_a), 32'(GUARD));

        // Asynchronous reset in the middle of a push
        do_reset();
        step(1, 0, 13'h021, 0);
        step(1, 0, 13'h022, 0);
        chk("ar_pre_level", 32'(level_a), 2);
        @(negedge clk);
        push = 1'b1; din = 13'h033;
        #2 reset = 1'b1;
        #1;
        chk("ar_level_now", 32'(level_a), 0);
        chk("ar_empty_now", 32'(empty_a), 1);
        @(posedge clk);
        #1;
        push = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("ar_nowrite", (dut.r_mem[2] == 13'h033) ? 32'd1 : 32'd0, 0);
        chk("ar_level", 32'(level_a), 0);
        step(1, 0, 13'h044, 0);
        chk("ar_after_top", 32'(top_a), 32'h044);
        chk("ar_after_level", 32'(level_a), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
